inv_mix_columns_iter: RTL and testbench

INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

---
 rtl/inv_mix_columns_iter.sv | 105 ++++++++++
 tb/tb_inv_mix_columns_iter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: a captured 128-bit state is transformed in place,
// COLS_PER_CYCLE columns per BUSY cycle, then held in DONE until the consumer takes it.
module inv_mix_columns_iter #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  // Column counter is 2 bits wide; a step of 4 wraps to 0 by construction.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int unsigned i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
          data_d[127-32*(cnt_q+j) -: 32] = inv_col(data_q[127-32*(cnt_q+j) -: 32]);
        end
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            data_d  = in_data;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_data  = data_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter: one instance per COLS_PER_CYCLE value, each running
// directed vectors, handshake timing checks and a MixColumns round trip via a scoreboard.
module tb_inv_mix_columns_iter;

  localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] FIXED    = 128'hc6c6c6c6_01010101_c6c6c6c6_01010101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Forward MixColumns, used to build round-trip stimulus.
  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      r[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int unsigned C = 1 << g;
    localparam int N = 4 / C;

    logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data, out_data;
    logic [127:0] sb [$];

    inv_mix_columns_iter #(.COLS_PER_CYCLE(C)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .busy     (busy)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      check($sformatf("C%0d_%s", C, tag), got, exp);
    endtask

    always @(negedge clk) begin
      if (rst === 1'b0 && out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out", out_data, 128'hx);
        else chk("data", out_data, sb.pop_front());
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] e, input bit rnd);
      int k = 0;
      bit hs = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      while (!hs && k < 100) begin
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        hs = in_ready;
        if (hs) sb.push_back(e);
        tick();
        k++;
      end
      in_valid = 1'b0;
      if (!hs) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
      int k = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 && k < 100) begin
        tick();
        k++;
      end
      chk("drain", sb.size(), 0);
    endtask

    initial begin
      int k;
      int nacc;
      int t [2];
      bit seen;
      logic [127:0] orig;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
      rst = 1'b0;

      // Latency: accepted in cycle 0, out_valid from cycle N+1.
      send(FIPS_IN, FIPS_OUT, 1'b0);
      chk("busy_after_accept", busy, 1);
      k = 1;
      while (!out_valid && k < 20) begin
        tick();
        k++;
      end
      chk("latency", k, N + 1);

      for (int i = 0; i < 10; i++) begin
        tick();
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_data", out_data, FIPS_OUT);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_busy", busy, 0);
      end
      drain();

      send(FIXED, FIXED, 1'b0);
      drain();
      send('0, '0, 1'b0);
      drain();

      // Back-to-back: second block accepted in the cycle the first result is taken.
      nacc = 0; k = 0;
      in_valid = 1'b1; in_data = FIPS_IN; out_ready = 1'b1;
      while (nacc < 2 && k < 50) begin
        #1;
        if (in_ready) begin
          t[nacc] = cyc;
          if (nacc == 0) sb.push_back(FIPS_OUT);
          else begin
            sb.push_back(FIXED);
            chk("b2b_same_cycle", out_valid, 1);
          end
          nacc++;
        end
        tick();
        if (nacc == 1) in_data = FIXED;
        k++;
      end
      in_valid = 1'b0;
      chk("b2b_accepts", nacc, 2);
      if (nacc == 2) chk("b2b_spacing", t[1] - t[0], N + 1);
      drain();

      // Reset during cycle 2 after acceptance discards the block.
      out_ready = 1'b0;
      send(FIPS_IN, FIPS_OUT, 1'b0);
      tick();
      rst = 1'b1;
      sb.delete();
      tick();
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_busy", busy, 0);
      rst = 1'b0;
      out_ready = 1'b1;
      seen = 1'b0;
      repeat (8) begin
        tick();
        if (out_valid) seen = 1'b1;
      end
      chk("no_stale", seen, 0);

      for (int i = 0; i < 1000; i++) begin
        orig = {$urandom, $urandom, $urandom, $urandom};
        send(mix(orig), orig, 1'b1);
      end
      drain();

      n_done++;
    end
  end

  initial begin
    int k = 0;
    while (n_done < 3 && k < 50000) begin
      @(posedge clk);
      k++;
    end
    if (n_done < 3) check("global_timeout", n_done, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
